pipeline_ctrl: RTL and testbench

- Central hazard/stall controller; drives the en/flush pair of every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Sits beside the datapath. Consumes hazard sources: fetch miss, data-memory wait, load-use, taken redirect, halt.
- Owns the multi-cycle load-use stall counter and the terminal halt state.

---
 rtl/cpu_types_pkg.sv | 72 +++++++
 rtl/pipeline_ctrl_hazard_detect.sv | 16 +
 rtl/pipeline_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register indices, pipeline-controller state, hazard rule
// encoding and the per-rule latch control pattern.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  localparam int LU_STALL_MAX = 3;

  typedef enum logic [1:0] {
    PC_RUN     = 2'd0,
    PC_LUSTALL = 2'd1,
    PC_HALT    = 2'd2
  } pipe_ctrl_state_t;

  typedef enum logic [2:0] {
    RULE_HALT     = 3'd0,
    RULE_WBHALT   = 3'd1,
    RULE_FREEZE   = 3'd2,
    RULE_REDIRECT = 3'd3,
    RULE_LOADUSE  = 3'd4,
    RULE_LUSTALL  = 3'd5,
    RULE_IFMISS   = 3'd6,
    RULE_NORMAL   = 3'd7
  } pipe_ctrl_rule_t;

  typedef struct packed {
    logic pc_en;
    logic if_en;
    logic if_flush;
    logic id_en;
    logic id_flush;
    logic ex_en;
    logic ex_flush;
    logic mem_en;
  } pipe_ctrl_t;

  // A flush always comes with its latch enable low, so no pattern sets both.
  function automatic pipe_ctrl_t ctrl_for_rule(input pipe_ctrl_rule_t rule);
    pipe_ctrl_t c;
    c = '0;
    case (rule)
      RULE_REDIRECT: begin
        c.pc_en    = 1'b1;
        c.if_flush = 1'b1;
        c.id_flush = 1'b1;
        c.ex_flush = 1'b1;
        c.mem_en   = 1'b1;
      end
      RULE_LOADUSE, RULE_LUSTALL: begin
        c.id_flush = 1'b1;
        c.ex_en    = 1'b1;
        c.mem_en   = 1'b1;
      end
      RULE_IFMISS: begin
        c.if_flush = 1'b1;
        c.id_en    = 1'b1;
        c.ex_en    = 1'b1;
        c.mem_en   = 1'b1;
      end
      RULE_NORMAL: begin
        c.pc_en  = 1'b1;
        c.if_en  = 1'b1;
        c.id_en  = 1'b1;
        c.ex_en  = 1'b1;
        c.mem_en = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID reads. Register 0 is hardwired and never stalls.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dREN,
  input  regbits_t ex_rt,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     lu_hazard
);

  assign lu_hazard = ex_dREN & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/stall controller driving every pipeline latch en/flush pair
// and the PC write enable. Optional perf counters: define PIPE_CTRL_PERF_EN.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int LU_STALL = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_dREN,
  input  logic        mem_dWEN,
  input  logic        ex_dREN,
  input  regbits_t    ex_rt,
  input  regbits_t    id_rs,
  input  regbits_t    id_rt,
  input  logic        mem_take,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        if_en,
  output logic        if_flush,
  output logic        id_en,
  output logic        id_flush,
  output logic        ex_en,
  output logic        ex_flush,
  output logic        mem_en,
  output logic        halted,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  pipe_ctrl_state_t state_r, state_nxt_s;
  logic [1:0]       lu_cnt_r, lu_cnt_nxt_s;
  logic             mem_busy_s;
  logic             lu_hazard_s;
  pipe_ctrl_rule_t  rule_s;
  pipe_ctrl_t       ctrl_s;

  hazard_detect u_hazard_detect (
    .ex_dREN   (ex_dREN),
    .ex_rt     (ex_rt),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .lu_hazard (lu_hazard_s)
  );

  assign mem_busy_s = (mem_dREN | mem_dWEN) & ~dhit;

  // Select the one rule governing this cycle; earlier checks win.
  always_comb begin
    rule_s = RULE_NORMAL;
    if (state_r == PC_HALT) begin
      rule_s = RULE_HALT;
    end else if (wb_halt) begin
      rule_s = RULE_WBHALT;
    end else if (mem_busy_s) begin
      rule_s = RULE_FREEZE;
    end else if (mem_take) begin
      rule_s = RULE_REDIRECT;
    end else if ((state_r == PC_RUN) && lu_hazard_s) begin
      rule_s = RULE_LOADUSE;
    end else if (state_r == PC_LUSTALL) begin
      rule_s = RULE_LUSTALL;
    end else if (!ihit) begin
      rule_s = RULE_IFMISS;
    end else begin
      rule_s = RULE_NORMAL;
    end
  end

  // Next-state and latch controls from the selected rule.
  always_comb begin
    state_nxt_s  = state_r;
    lu_cnt_nxt_s = lu_cnt_r;
    ctrl_s       = ctrl_for_rule(rule_s);
    case (rule_s)
      RULE_HALT, RULE_WBHALT: begin
        state_nxt_s = PC_HALT;
      end
      RULE_FREEZE: begin
        state_nxt_s  = state_r;
        lu_cnt_nxt_s = lu_cnt_r;
      end
      RULE_REDIRECT: begin
        state_nxt_s  = PC_RUN;
        lu_cnt_nxt_s = 2'd0;
      end
      RULE_LOADUSE: begin
        // A single bubble needs no extra state: the load leaves EX next cycle.
        if (LU_STALL > 1) begin
          state_nxt_s  = PC_LUSTALL;
          lu_cnt_nxt_s = 2'(LU_STALL - 1);
        end else begin
          state_nxt_s  = PC_RUN;
          lu_cnt_nxt_s = 2'd0;
        end
      end
      RULE_LUSTALL: begin
        if (lu_cnt_r <= 2'd1) begin
          state_nxt_s  = PC_RUN;
          lu_cnt_nxt_s = 2'd0;
        end else begin
          state_nxt_s  = PC_LUSTALL;
          lu_cnt_nxt_s = lu_cnt_r - 2'd1;
        end
      end
      RULE_IFMISS, RULE_NORMAL: begin
        state_nxt_s  = PC_RUN;
        lu_cnt_nxt_s = 2'd0;
      end
      default: begin
        state_nxt_s  = PC_RUN;
        lu_cnt_nxt_s = 2'd0;
      end
    endcase
  end

  // Controller state register; reset aborts any stall in progress.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r  <= PC_RUN;
      lu_cnt_r <= 2'd0;
    end else begin
      state_r  <= state_nxt_s;
      lu_cnt_r <= lu_cnt_nxt_s;
    end
  end

  assign pc_en    = ctrl_s.pc_en;
  assign if_en    = ctrl_s.if_en;
  assign if_flush = ctrl_s.if_flush;
  assign id_en    = ctrl_s.id_en;
  assign id_flush = ctrl_s.id_flush;
  assign ex_en    = ctrl_s.ex_en;
  assign ex_flush = ctrl_s.ex_flush;
  assign mem_en   = ctrl_s.mem_en;
  assign halted   = (state_r == PC_HALT);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;
  logic        stall_ev_s;
  logic        flush_ev_s;

  // HALT maps to its own rule, so the counters freeze there naturally.
  assign stall_ev_s = (rule_s == RULE_FREEZE)  | (rule_s == RULE_LOADUSE) |
                      (rule_s == RULE_LUSTALL) | (rule_s == RULE_IFMISS);
  assign flush_ev_s = (rule_s == RULE_REDIRECT);

  // Free-running wrap-around performance counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (stall_ev_s) stall_cnt_r <= stall_cnt_r + 32'd1;
      if (flush_ev_s) flush_cnt_r <= flush_cnt_r + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_r;
  assign flush_events = flush_cnt_r;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed test-plan sequences followed by
// randomized traffic, checked against a behavioural model of the stall rules.
module tb_pipeline_ctrl;
  localparam int LU = 2;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        ihit = 1'b0, dhit = 1'b0, mem_dREN = 1'b0, mem_dWEN = 1'b0;
  logic        ex_dREN = 1'b0, mem_take = 1'b0, wb_halt = 1'b0;
  logic [4:0]  ex_rt = 5'd0, id_rs = 5'd0, id_rt = 5'd0;
  logic        pc_en, if_en, if_flush, id_en, id_flush, ex_en, ex_flush, mem_en, halted;
  logic [31:0] stall_cycles, flush_events;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.LU_STALL(LU)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN),
    .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .mem_take(mem_take), .wb_halt(wb_halt),
    .pc_en(pc_en), .if_en(if_en), .if_flush(if_flush),
    .id_en(id_en), .id_flush(id_flush), .ex_en(ex_en), .ex_flush(ex_flush),
    .mem_en(mem_en), .halted(halted),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [31:0] sc;
    logic [31:0] fe;
    logic [7:0]  tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  logic [8:0] mon_got;
  int errors = 0;
  int checks = 0;

  // Reference model: halted flag, bubbles still owed, event tallies.
  bit          m_halted = 1'b0;
  int          m_left = 0;
  int unsigned m_sc = 0, m_fe = 0;

  task automatic step(input bit rst_n, input bit ih, input bit dh, input bit mr,
                      input bit mw, input bit er, input logic [4:0] ert,
                      input logic [4:0] irs, input logic [4:0] irt,
                      input bit tk, input bit hl, input logic [7:0] tag);
    exp_t e;
    bit busy, hz;
    logic [8:0] c;
    @(posedge CLK);
    #1;
    nRST = rst_n; ihit = ih; dhit = dh; mem_dREN = mr; mem_dWEN = mw;
    ex_dREN = er; ex_rt = ert; id_rs = irs; id_rt = irt; mem_take = tk; wb_halt = hl;
    if (!rst_n) begin
      m_halted = 1'b0; m_left = 0; m_sc = 0; m_fe = 0;
    end
    busy = (mr || mw) && !dh;
    hz = er && (ert != 5'd0) && (ert == irs || ert == irt);
    e.sc = 32'(m_sc);
    e.fe = 32'(m_fe);
    // Bit order: pc_en if_en if_flush id_en id_flush ex_en ex_flush mem_en halted
    if (m_halted) begin
      c = 9'b000000001;
    end else if (hl) begin
      c = 9'b000000000; m_halted = 1'b1;
    end else if (busy) begin
      c = 9'b000000000; m_sc++;
    end else if (tk) begin
      c = 9'b101010110; m_left = 0; m_fe++;
    end else if (m_left > 0) begin
      c = 9'b000011010; m_left--; m_sc++;
    end else if (hz) begin
      c = 9'b000011010; m_left = LU - 1; m_sc++;
    end else if (!ih) begin
      c = 9'b001101010; m_sc++;
    end else begin
      c = 9'b110101010;
    end
    if (!rst_n) begin
      m_halted = 1'b0; m_left = 0; m_sc = 0; m_fe = 0;
    end
    e.ctrl = c;
`ifndef PIPE_CTRL_PERF_EN
    e.sc = 32'd0;
    e.fe = 32'd0;
`endif
    e.tag = tag;
    sbq.push_back(e);
  endtask

  function automatic logic [4:0] pick();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'd17;
    endcase
  endfunction

  // Monitor: compare each presented cycle against the oldest expectation.
  always @(negedge CLK) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      mon_got = {pc_en, if_en, if_flush, id_en, id_flush, ex_en, ex_flush, mem_en, halted};
      checks++;
      if (mon_got !== mon_e.ctrl) begin
        errors++;
        $display("FAIL ctrl tag=%0d got=%b exp=%b", mon_e.tag, mon_got, mon_e.ctrl);
      end
      checks++;
      if (stall_cycles !== mon_e.sc) begin
        errors++;
        $display("FAIL stall_cycles tag=%0d got=%0d exp=%0d", mon_e.tag, stall_cycles, mon_e.sc);
      end
      checks++;
      if (flush_events !== mon_e.fe) begin
        errors++;
        $display("FAIL flush_events tag=%0d got=%0d exp=%0d", mon_e.tag, flush_events, mon_e.fe);
      end
    end
  end

  initial begin
    bit rs, ih, dh, mr, mw, er, tk, hl;
    #2 nRST = 1'b0;
    // Reset then hazard-free flow
    repeat (2) step(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'd1);
    repeat (3) step(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'd1);
    // Load-use on rs: two bubbles then resume
    step(1, 1, 1, 0, 0, 1, 5'd8, 5'd8, 5'd3, 0, 0, 8'd2);
    repeat (3) step(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'd2);
    // r0 never stalls
    repeat (2) step(1, 1, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 8'd3);
    // Memory wait during LUSTALL freezes everything, stall resumes after
    step(1, 1, 1, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 8'd4);
    repeat (3) step(1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'd4);
    step(1, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'd4);
    repeat (2) step(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'd4);
    // Redirect beats a simultaneous load-use (match on rt)
    step(1, 1, 1, 0, 0, 1, 5'd8, 5'd1, 5'd8, 1, 0, 8'd5);
    repeat (2) step(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'd5);
    // Instruction miss with and without a coincident load-use
    step(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'd6);
    step(1, 0, 1, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 8'd6);
    step(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'd6);
    // Halt pulse is sticky until reset
    step(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 8'd7);
    for (int i = 0; i < 4; i++) step(1, i[0], 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'd7);
    step(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'd7);
    repeat (2) step(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'd7);
    // Reset mid-stall aborts the stall
    step(1, 1, 1, 0, 0, 1, 5'd17, 5'd17, 5'd0, 0, 0, 8'd8);
    step(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'd8);
    repeat (2) step(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'd8);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs = !($urandom_range(0, 199) == 0 || (m_halted && $urandom_range(0, 3) == 0));
      ih = ($urandom_range(0, 4) != 0);
      dh = ($urandom_range(0, 2) != 0);
      mr = ($urandom_range(0, 5) == 0);
      mw = ($urandom_range(0, 7) == 0);
      er = ($urandom_range(0, 1) == 1);
      tk = ($urandom_range(0, 9) == 0);
      hl = ($urandom_range(0, 299) == 0);
      step(rs, ih, dh, mr, mw, er, pick(), pick(), pick(), tk, hl, 8'd100);
    end
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge CLK);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
